// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin owner of one shared SPI master transmitter.
// Optional per-phase watchdog is enabled by defining SPI_ARB_TIMEOUT_EN.
module spi_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 12,
   parameter int TIMEOUT = 8191
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic [NUM_REQ-1:0]        i_req,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_data,
   output logic [NUM_REQ-1:0]        o_grant,
   output logic [NUM_REQ-1:0]        o_ack,
   output logic [NUM_REQ-1:0]        o_err,
   output logic                      o_spi_newd,
   output logic [DATA_W-1:0]         o_spi_din,
   input  logic                      i_spi_cs
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_XFER   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
   logic [NUM_REQ-1:0]  r_ack, w_ack_nxt;
   logic [NUM_REQ-1:0]  r_err, w_err_nxt;
   logic                r_newd, w_newd_nxt;
   logic [DATA_W-1:0]   r_din, w_din_nxt;
   logic [PTR_W-1:0]    r_ptr, w_ptr_nxt;
   logic [PTR_W-1:0]    r_owner, w_owner_nxt;
   logic [PTR_W-1:0]    w_ptr_adv, w_win, w_idx;
   logic                w_found, w_tmo;
   logic                r_cs_meta, r_cs_sync;
   logic [DATA_W-1:0]   w_data [NUM_REQ];
   int                  w_sum;

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
      $error("spi_tx_arbiter: NUM_REQ must be 2..8 and TIMEOUT positive");
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign w_data[g] = i_req_data[g*DATA_W +: DATA_W];
   end

   assign w_ptr_adv = (r_owner == PTR_W'(NUM_REQ - 1)) ? {PTR_W{1'b0}} : r_owner + PTR_W'(1);

   // Round-robin search: first requester at or after r_ptr, wrapping
   always_comb begin
      w_found = 1'b0;
      w_win   = {PTR_W{1'b0}};
      w_sum   = 0;
      w_idx   = {PTR_W{1'b0}};
      for (int k = 0; k < NUM_REQ; k++) begin
         w_sum = int'(r_ptr) + k;
         if (w_sum >= NUM_REQ) begin
            w_sum = w_sum - NUM_REQ;
         end else begin
            w_sum = w_sum;
         end
         w_idx = PTR_W'(w_sum);
         if (!w_found && i_req[w_idx]) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end else begin
            w_win   = w_win;
         end
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int TMR_W = $clog2(TIMEOUT + 1);
   logic [TMR_W-1:0] r_timer, w_timer_nxt;
   logic             w_busy;

   // Watchdog restarts on every phase entry and runs while launching or transferring
   always_comb begin
      w_busy = (r_state == S_LAUNCH) || (r_state == S_XFER);
      w_tmo  = w_busy && (r_timer == TMR_W'(TIMEOUT));
      if (!w_busy || w_tmo || ((r_state == S_LAUNCH) && !r_cs_sync)) begin
         w_timer_nxt = {TMR_W{1'b0}};
      end else begin
         w_timer_nxt = r_timer + TMR_W'(1);
      end
   end

   // Watchdog counter register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_timer <= {TMR_W{1'b0}};
      end else begin
         r_timer <= w_timer_nxt;
      end
   end
`else
   assign w_tmo = 1'b0;
`endif

   // Next-state and next-output logic
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_ack_nxt   = {NUM_REQ{1'b0}};
      w_err_nxt   = {NUM_REQ{1'b0}};
      w_newd_nxt  = r_newd;
      w_din_nxt   = r_din;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = r_owner;
      if (w_tmo) begin
         w_state_nxt = S_IDLE;
         w_err_nxt   = r_grant;
         w_grant_nxt = {NUM_REQ{1'b0}};
         w_newd_nxt  = 1'b0;
         w_ptr_nxt   = w_ptr_adv;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  w_state_nxt = S_LAUNCH;
                  w_grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
                  w_din_nxt   = w_data[w_win];
                  w_owner_nxt = w_win;
               end else begin
                  w_grant_nxt = {NUM_REQ{1'b0}};
               end
            end
            // cs already low here (foreign frame) counts as acceptance too
            S_LAUNCH: begin
               if (!r_cs_sync) begin
                  w_newd_nxt  = 1'b0;
                  w_state_nxt = S_XFER;
               end else begin
                  w_newd_nxt  = 1'b1;
               end
            end
            S_XFER: begin
               if (r_cs_sync) begin
                  w_state_nxt = S_DONE;
                  w_ack_nxt   = r_grant;
                  w_grant_nxt = {NUM_REQ{1'b0}};
                  w_ptr_nxt   = w_ptr_adv;
               end else begin
                  w_state_nxt = S_XFER;
               end
            end
            S_DONE: begin
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_grant_nxt = {NUM_REQ{1'b0}};
               w_newd_nxt  = 1'b0;
            end
         endcase
      end
   end

   // Two-flop synchroniser for the master's chip select (idles high)
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cs_meta <= 1'b1;
         r_cs_sync <= 1'b1;
      end else begin
         r_cs_meta <= i_spi_cs;
         r_cs_sync <= r_cs_meta;
      end
   end

   // State and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
         r_grant <= {NUM_REQ{1'b0}};
         r_ack   <= {NUM_REQ{1'b0}};
         r_err   <= {NUM_REQ{1'b0}};
         r_newd  <= 1'b0;
         r_din   <= {DATA_W{1'b0}};
         r_ptr   <= {PTR_W{1'b0}};
         r_owner <= {PTR_W{1'b0}};
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_ack   <= w_ack_nxt;
         r_err   <= w_err_nxt;
         r_newd  <= w_newd_nxt;
         r_din   <= w_din_nxt;
         r_ptr   <= w_ptr_nxt;
         r_owner <= w_owner_nxt;
      end
   end

   assign o_grant    = r_grant;
   assign o_ack      = r_ack;
   assign o_err      = r_err;
   assign o_spi_newd = r_newd;
   assign o_spi_din  = r_din;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Scoreboard bench for spi_tx_arbiter with a simple SPI master model.
// Timeout scenario runs only when SPI_ARB_TIMEOUT_EN is defined.
module tb_spi_tx_arbiter;
   localparam int NR = 4;
   localparam int DW = 12;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR-1:0]    req;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]    o_grant, o_ack, o_err;
   logic             o_spi_newd;
   logic [DW-1:0]    o_spi_din;
   logic             spi_cs;

   int checks = 0;
   int errors = 0;
   int ack_count = 0;
   int err_count = 0;

   logic [NR-1:0] exp_grant_q[$];
   logic [NR-1:0] exp_ack_q[$];
   logic [DW-1:0] exp_data_q[$];
   logic [NR-1:0] exp_err_q[$];
   logic [DW-1:0] last_frame = 12'h000;
   logic          cs_stuck = 1'b0;

   spi_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(100)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_req_data(req_data),
      .o_grant(o_grant), .o_ack(o_ack), .o_err(o_err),
      .o_spi_newd(o_spi_newd), .o_spi_din(o_spi_din), .i_spi_cs(spi_cs)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops expectations whenever grant rises, ack pulses or err pulses
   initial begin
      logic [NR-1:0] prev_grant;
      prev_grant = 4'b0000;
      forever begin
         @(negedge clk);
         if (o_grant != 4'b0000 && prev_grant == 4'b0000) begin
            if (exp_grant_q.size() == 0) chk("grant_unexpected", 32'(o_grant), 32'd0);
            else chk("grant_order", 32'(o_grant), 32'(exp_grant_q.pop_front()));
         end
         prev_grant = o_grant;
         if (o_ack != 4'b0000) begin
            ack_count++;
            chk("no_grant_during_ack", 32'(o_grant), 32'd0);
            if (exp_ack_q.size() == 0) chk("ack_unexpected", 32'(o_ack), 32'd0);
            else begin
               chk("ack_owner", 32'(o_ack), 32'(exp_ack_q.pop_front()));
               chk("frame_data", 32'(last_frame), 32'(exp_data_q.pop_front()));
            end
         end
         if (o_err != 4'b0000) begin
            err_count++;
            if (exp_err_q.size() == 0) chk("err_unexpected", 32'(o_err), 32'd0);
            else chk("err_owner", 32'(o_err), 32'(exp_err_q.pop_front()));
         end
      end
   end

   // SPI master model: accepts newd, shifts 12 bits LSB first from spi_din
   initial begin
      logic [DW-1:0] frame, sh;
      spi_cs = 1'b1;
      frame  = 12'h000;
      forever begin
         @(negedge clk);
         if (o_spi_newd && !cs_stuck) begin
            repeat (2) begin
               @(negedge clk);
               chk("newd_held", 32'(o_spi_newd), 32'd1);
            end
            spi_cs = 1'b0;
            for (int i = 0; i < DW; i++) begin
               @(negedge clk);
               sh    = o_spi_din >> i;
               frame = {sh[0], frame[DW-1:1]};
            end
            chk("newd_dropped", 32'(o_spi_newd), 32'd0);
            last_frame = frame;
            spi_cs = 1'b1;
         end
      end
   end

   task automatic wait_acks(input int target);
      int n;
      n = 0;
      while (ack_count < target && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (ack_count < target) chk("ack_timeout", 32'(ack_count), 32'(target));
   endtask

   task automatic wait_cs_low();
      int n;
      n = 0;
      while (spi_cs !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (spi_cs !== 1'b0) chk("cs_low_timeout", 32'(spi_cs), 32'd0);
   endtask

   task automatic expect_frame(input logic [NR-1:0] who, input logic [DW-1:0] data);
      exp_grant_q.push_back(who);
      exp_ack_q.push_back(who);
      exp_data_q.push_back(data);
   endtask

`ifdef SPI_ARB_TIMEOUT_EN
   task automatic wait_errs(input int target);
      int n;
      n = 0;
      while (err_count < target && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (err_count < target) chk("err_timeout", 32'(err_count), 32'(target));
   endtask
`endif

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got running expected done");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      req_data = {NR*DW{1'b0}};
      repeat (3) @(negedge clk);
      chk("rst_grant", 32'(o_grant), 32'd0);
      chk("rst_ack", 32'(o_ack), 32'd0);
      chk("rst_err", 32'(o_err), 32'd0);
      chk("rst_newd", 32'(o_spi_newd), 32'd0);
      chk("rst_din", 32'(o_spi_din), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Contention: all four held, strict rotation from requester 0
      req_data = {12'h888, 12'h444, 12'h222, 12'h111};
      expect_frame(4'b0001, 12'h111);
      expect_frame(4'b0010, 12'h222);
      expect_frame(4'b0100, 12'h444);
      expect_frame(4'b1000, 12'h888);
      expect_frame(4'b0001, 12'h111);
      req = 4'b1111;
      wait_acks(5);
      req = 4'b0000;
      repeat (3) @(negedge clk);

      // Single requester 1 with latency checks
      req_data[23:12] = 12'hA5C;
      expect_frame(4'b0010, 12'hA5C);
      req = 4'b0010;
      @(negedge clk);
      chk("grant_latency", 32'(o_grant), 32'h2);
      chk("newd_not_yet", 32'(o_spi_newd), 32'd0);
      @(negedge clk);
      chk("newd_latency", 32'(o_spi_newd), 32'd1);
      wait_acks(6);
      req = 4'b0000;
      repeat (3) @(negedge clk);

      // Serve requester 2 so the pointer sits at 3, then wrap/skip with 0101
      req_data[35:24] = 12'h3A7;
      req_data[11:0]  = 12'h0C5;
      expect_frame(4'b0100, 12'h3A7);
      req = 4'b0100;
      wait_acks(7);
      req = 4'b0000;
      repeat (3) @(negedge clk);
      expect_frame(4'b0001, 12'h0C5);
      expect_frame(4'b0100, 12'h3A7);
      expect_frame(4'b0001, 12'h0C5);
      req = 4'b0101;
      wait_acks(10);
      req = 4'b0000;
      repeat (3) @(negedge clk);

      // Payload changes during the frame must not reach the master
      req_data[11:0] = 12'h3C1;
      expect_frame(4'b0001, 12'h3C1);
      req = 4'b0001;
      wait_cs_low();
      repeat (2) @(negedge clk);
      req_data[11:0] = 12'hFFF;
      wait_acks(11);
      req = 4'b0000;
      repeat (3) @(negedge clk);

      // Reset in the middle of a transfer: no ack, pointer back to 0
      req_data[35:24] = 12'h5A5;
      exp_grant_q.push_back(4'b0100);
      req = 4'b0100;
      wait_cs_low();
      repeat (3) @(negedge clk);
      req = 4'b0000;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_grant", 32'(o_grant), 32'd0);
      chk("midrst_ack", 32'(o_ack), 32'd0);
      chk("midrst_newd", 32'(o_spi_newd), 32'd0);
      repeat (20) @(negedge clk);
      chk("midrst_no_ack", 32'(ack_count), 32'd11);
      req_data[11:0]  = 12'h0F0;
      req_data[47:36] = 12'h909;
      expect_frame(4'b0001, 12'h0F0);
      req = 4'b1001;
      wait_acks(12);
      req = 4'b0000;
      repeat (3) @(negedge clk);

`ifdef SPI_ARB_TIMEOUT_EN
      // cs stuck high: requester 1 times out, requester 2 is served next
      cs_stuck = 1'b1;
      req_data[23:12] = 12'h1E1;
      req_data[35:24] = 12'h6B6;
      exp_grant_q.push_back(4'b0010);
      exp_err_q.push_back(4'b0010);
      expect_frame(4'b0100, 12'h6B6);
      req = 4'b0110;
      wait_errs(1);
      cs_stuck = 1'b0;
      wait_acks(13);
      req = 4'b0000;
      repeat (3) @(negedge clk);
`endif

      repeat (5) @(negedge clk);
      chk("queues_drained", 32'(exp_grant_q.size() + exp_ack_q.size() + exp_err_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
